// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the 2R1W register file
// Purpose: default geometry, hardwired-zero index and address range check.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int REG_ZERO      = 0;

  // True when addr selects an implemented entry (DEPTH need not be a power of 2).
  function automatic logic rf_addr_valid(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_2r1w_cell.sv
// rtl/regfile_2r1w_cell.sv - one WIDTH-bit storage entry of the register file
// Purpose: register with async active-high clear and synchronous load enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q to 0
//   load - when high at a rising edge, q takes d
//   d    - load data
//   q    - stored value
module rf_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - DEPTH x WIDTH register file, 1 sync write, 2 comb reads
// Purpose: operand storage between decode and ALU, optional zero entry and bypass.
// Ports:
//   clk, rst         - clock, async active-high reset (clears all entries)
//   we, waddr, wdata - write port, sampled at rising clk
//   raddr_a, rdata_a - read port A, combinational
//   raddr_b, rdata_b - read port B, combinational
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic             wr_ok;

  // A write only takes effect (and is only bypassed) when it will really
  // change state: out-of-range and zero-entry writes are dropped here.
  assign wr_ok = we && !rst
                 && rf_addr_valid(32'(waddr), DEPTH)
                 && !(ZERO_REG != 0 && waddr == AW'(REG_ZERO));

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    if (ZERO_REG != 0 && i == REG_ZERO) begin : g_zero
      assign entry_q[i] = '0;
    end else begin : g_store
      rf_cell #(.WIDTH(WIDTH)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .load (wr_ok && (waddr == AW'(i))),
        .d    (wdata),
        .q    (entry_q[i])
      );
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    logic             addr_ok;

    assign ra      = (p == 0) ? raddr_a : raddr_b;
    // Range check guards the array index so unimplemented addresses read 0, not X.
    assign addr_ok = rf_addr_valid(32'(ra), DEPTH)
                     && !(ZERO_REG != 0 && ra == AW'(REG_ZERO));

    always_comb begin
      rd = '0;
      if (rst) begin
        rd = '0;
      end else if (BYPASS != 0 && wr_ok && ra == waddr) begin
        rd = wdata;
      end else if (addr_ok) begin
        rd = entry_q[ra];
      end
    end
  end

  assign rdata_a = g_rd[0].rd;
  assign rdata_b = g_rd[1].rd;

endmodule
